// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it into a 32 x XLEN
// integer register file (x0 hardwired to zero), exposes two combinational read
// ports, a zero-latency EX forwarding tap and a retired-instruction counter.
// Optional build macro: REGFILE_BYPASS_EN enables write-before-read bypass on
// the read ports.
module wb_regfile #(
   parameter int XLEN     = 32,
   parameter int PC_BITS  = 32,
   parameter int CNT_BITS = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                WB_valid,
   input  logic [XLEN-1:0]     WB_data_mem,
   input  logic [4:0]          WB_rd,
   input  logic                WB_we,
   input  logic [PC_BITS-1:0]  WB_pc,
   input  logic                WB_jlx,
   input  logic [4:0]          ID_rs1,
   input  logic [4:0]          ID_rs2,
   output logic [XLEN-1:0]     ID_rs1_data,
   output logic [XLEN-1:0]     ID_rs2_data,
   output logic                WB_fwd_valid,
   output logic [4:0]          WB_fwd_rd,
   output logic [XLEN-1:0]     WB_fwd_data,
   output logic [CNT_BITS-1:0] instret
);

   logic [XLEN-1:0]     regs [32];
   logic [XLEN-1:0]     pc_ext;
   logic [XLEN-1:0]     wb_val;
   logic                commit;
   logic [CNT_BITS-1:0] instret_q;

   // The link address is computed in XLEN bits, so the PC is fitted to XLEN first.
   generate
      if (PC_BITS >= XLEN) begin : g_pc_trunc
         assign pc_ext = WB_pc[XLEN-1:0];
      end else begin : g_pc_zext
         assign pc_ext = {{(XLEN-PC_BITS){1'b0}}, WB_pc};
      end
   endgenerate

   // A bubble gates everything else, so X on WB_we/WB_rd cannot corrupt state.
   assign wb_val = WB_jlx ? (pc_ext + XLEN'(4)) : WB_data_mem;
   assign commit = WB_valid & WB_we & (WB_rd != 5'd0);

   assign WB_fwd_valid = commit;
   assign WB_fwd_rd    = WB_rd;
   assign WB_fwd_data  = wb_val;

   // NOTE: the architectural registers must be zero after reset, so this array is
   // reset explicitly; that keeps it in flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         // NOTE: state is updated with non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         regs[WB_rd] <= wb_val;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instret_q <= '0;
      end else if (WB_valid) begin
         instret_q <= instret_q + CNT_BITS'(1);
      end
   end

   assign instret = instret_q;

   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned (no latch).
      ID_rs1_data = '0;
      ID_rs2_data = '0;
      if (ID_rs1 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
         ID_rs1_data = (commit && (ID_rs1 == WB_rd)) ? wb_val : regs[ID_rs1];
`else
         ID_rs1_data = regs[ID_rs1];
`endif
      end
      if (ID_rs2 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
         ID_rs2_data = (commit && (ID_rs2 == WB_rd)) ? wb_val : regs[ID_rs2];
`else
         ID_rs2_data = regs[ID_rs2];
`endif
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile; build with +define+REGFILE_BYPASS_EN to
// exercise the bypass build.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        WB_valid;
   logic [31:0] WB_data_mem;
   logic [4:0]  WB_rd;
   logic        WB_we;
   logic [31:0] WB_pc;
   logic        WB_jlx;
   logic [4:0]  ID_rs1;
   logic [4:0]  ID_rs2;
   logic [31:0] ID_rs1_data;
   logic [31:0] ID_rs2_data;
   logic        WB_fwd_valid;
   logic [4:0]  WB_fwd_rd;
   logic [31:0] WB_fwd_data;
   logic [63:0] instret;

   int tests_run;
   int tests_failed;

   wb_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .WB_valid     (WB_valid),
      .WB_data_mem  (WB_data_mem),
      .WB_rd        (WB_rd),
      .WB_we        (WB_we),
      .WB_pc        (WB_pc),
      .WB_jlx       (WB_jlx),
      .ID_rs1       (ID_rs1),
      .ID_rs2       (ID_rs2),
      .ID_rs1_data  (ID_rs1_data),
      .ID_rs2_data  (ID_rs2_data),
      .WB_fwd_valid (WB_fwd_valid),
      .WB_fwd_rd    (WB_fwd_rd),
      .WB_fwd_data  (WB_fwd_data),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      WB_valid    = 1'b0;
      WB_we       = 1'b0;
      WB_jlx      = 1'b0;
      WB_rd       = 5'd0;
      WB_data_mem = 32'h0;
      WB_pc       = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      ID_rs1 = 5'd0;
      ID_rs2 = 5'd0;
      tick();
      tests_run++;
      if (instret !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_instret: got %0d expected 0", instret);
      end
      WB_rd = 5'd9; WB_data_mem = 32'h0000_0077;
      #1;
      tests_run++;
      if (WB_fwd_rd !== 5'd9 || WB_fwd_data !== 32'h0000_0077 || WB_fwd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_fwd_follow: got v=%b rd=%0d d=%h expected v=0 rd=9 d=00000077",
                  WB_fwd_valid, WB_fwd_rd, WB_fwd_data);
      end
      idle();
      rst = 1'b1;
      for (int i = 1; i < 32; i++) begin
         ID_rs1 = 5'(i);
         ID_rs2 = 5'(i);
         #1;
         tests_run++;
         if (ID_rs1_data !== 32'h0 || ID_rs2_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_read x%0d: got %h/%h expected 0/0", i, ID_rs1_data, ID_rs2_data);
         end
      end
      tick();
      tests_run++;
      if (instret !== 64'd0) begin
         tests_failed++;
         $display("FAIL post_reset_instret: got %0d expected 0", instret);
      end
   endtask

   task automatic test_bubble();
      WB_valid = 1'b0; WB_we = 1'b1; WB_rd = 5'bx; WB_data_mem = 'x; WB_jlx = 1'bx;
      tick();
      WB_rd = 5'd9; WB_data_mem = 32'hBAD0_BAD0; WB_jlx = 1'b0;
      #1;
      tests_run++;
      if (WB_fwd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bubble_fwd_valid: got %b expected 0", WB_fwd_valid);
      end
      tick();
      idle();
      ID_rs1 = 5'd9; ID_rs2 = 5'd1;
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'h0 || ID_rs2_data !== 32'h0 || instret !== 64'd0) begin
         tests_failed++;
         $display("FAIL bubble_state: got x9=%h x1=%h instret=%0d expected 0 0 0",
                  ID_rs1_data, ID_rs2_data, instret);
      end
   endtask

   task automatic test_write_read();
      WB_valid = 1'b1; WB_we = 1'b1; WB_rd = 5'd5; WB_data_mem = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (WB_fwd_valid !== 1'b1 || WB_fwd_rd !== 5'd5 || WB_fwd_data !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL write_fwd: got v=%b rd=%0d d=%h expected v=1 rd=5 d=deadbeef",
                  WB_fwd_valid, WB_fwd_rd, WB_fwd_data);
      end
      tick();
      idle();
      ID_rs1 = 5'd5; ID_rs2 = 5'd4;
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'hDEAD_BEEF || ID_rs2_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL write_read: got x5=%h x4=%h expected deadbeef 0", ID_rs1_data, ID_rs2_data);
      end
      tests_run++;
      if (instret !== 64'd1) begin
         tests_failed++;
         $display("FAIL write_instret: got %0d expected 1", instret);
      end
   endtask

   task automatic test_jal();
      WB_valid = 1'b1; WB_we = 1'b1; WB_jlx = 1'b1; WB_rd = 5'd1;
      WB_pc = 32'h0000_1000; WB_data_mem = 32'h5555_5555;
      #1;
      tests_run++;
      if (WB_fwd_data !== 32'h0000_1004) begin
         tests_failed++;
         $display("FAIL jal_fwd: got %h expected 00001004", WB_fwd_data);
      end
      tick();
      idle();
      ID_rs1 = 5'd1;
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'h0000_1004 || instret !== 64'd2) begin
         tests_failed++;
         $display("FAIL jal_link: got x1=%h instret=%0d expected 00001004 2", ID_rs1_data, instret);
      end
      WB_valid = 1'b1; WB_we = 1'b1; WB_jlx = 1'b1; WB_rd = 5'd1;
      WB_pc = 32'hFFFF_FFFC; WB_data_mem = 32'h5555_5555;
      tick();
      idle();
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'h0000_0000 || instret !== 64'd3) begin
         tests_failed++;
         $display("FAIL jal_wrap: got x1=%h instret=%0d expected 00000000 3", ID_rs1_data, instret);
      end
   endtask

   task automatic test_x0();
      WB_valid = 1'b1; WB_we = 1'b1; WB_rd = 5'd0; WB_data_mem = 32'h1234_5678;
      ID_rs1 = 5'd0; ID_rs2 = 5'd0;
      #1;
      tests_run++;
      if (WB_fwd_valid !== 1'b0 || ID_rs1_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL x0_fwd: got v=%b x0=%h expected 0 0", WB_fwd_valid, ID_rs1_data);
      end
      tick();
      idle();
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'h0 || ID_rs2_data !== 32'h0 || instret !== 64'd4) begin
         tests_failed++;
         $display("FAIL x0_write: got %h/%h instret=%0d expected 0/0 4", ID_rs1_data, ID_rs2_data, instret);
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] exp_same;
      WB_valid = 1'b1; WB_we = 1'b1; WB_rd = 5'd7; WB_data_mem = 32'h1111_1111;
      tick();
      WB_data_mem = 32'hA5A5_A5A5;
      ID_rs1 = 5'd7; ID_rs2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hA5A5_A5A5;
`else
      exp_same = 32'h1111_1111;
`endif
      #1;
      tests_run++;
      if (ID_rs2_data !== exp_same || ID_rs1_data !== exp_same) begin
         tests_failed++;
         $display("FAIL same_cycle_read: got %h/%h expected %h", ID_rs1_data, ID_rs2_data, exp_same);
      end
      tick();
      idle();
      #1;
      tests_run++;
      if (ID_rs2_data !== 32'hA5A5_A5A5 || ID_rs1_data !== 32'hA5A5_A5A5 || instret !== 64'd6) begin
         tests_failed++;
         $display("FAIL same_cycle_next: got %h/%h instret=%0d expected a5a5a5a5 6",
                  ID_rs1_data, ID_rs2_data, instret);
      end
   endtask

   task automatic test_instret_reset();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         WB_valid = 1'b1;
         WB_we = (i < 6);
         WB_rd = 5'(10 + i);
         WB_data_mem = 32'h100 + 32'(i);
         tick();
      end
      idle();
      ID_rs1 = 5'd10; ID_rs2 = 5'd15;
      #1;
      tests_run++;
      if (instret !== 64'd10) begin
         tests_failed++;
         $display("FAIL burst_instret: got %0d expected 10", instret);
      end
      tests_run++;
      if (ID_rs1_data !== 32'h100 || ID_rs2_data !== 32'h105) begin
         tests_failed++;
         $display("FAIL burst_regs: got x10=%h x15=%h expected 00000100 00000105", ID_rs1_data, ID_rs2_data);
      end
      ID_rs1 = 5'd16;
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL burst_no_we: got x16=%h expected 0", ID_rs1_data);
      end
      // Assert reset asynchronously mid-cycle while a commit is pending.
      WB_valid = 1'b1; WB_we = 1'b1; WB_rd = 5'd20; WB_data_mem = 32'hFF;
      #1;
      rst = 1'b0;
      #1;
      tests_run++;
      if (instret !== 64'd0) begin
         tests_failed++;
         $display("FAIL async_reset_instret: got %0d expected 0", instret);
      end
      for (int i = 1; i < 32; i++) begin
         ID_rs1 = 5'(i);
         ID_rs2 = 5'(32 - i);
         #1;
         tests_run++;
         if (ID_rs1_data !== 32'h0 || ID_rs2_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset_regs x%0d: got %h/%h expected 0/0", i, ID_rs1_data, ID_rs2_data);
         end
      end
      tick();
      ID_rs1 = 5'd20;
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'h0 || instret !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_discard: got x20=%h instret=%0d expected 0 0", ID_rs1_data, instret);
      end
      idle();
      rst = 1'b1;
      WB_valid = 1'b1; WB_we = 1'b1; WB_rd = 5'd3; WB_data_mem = 32'h33;
      tick();
      idle();
      ID_rs1 = 5'd3;
      #1;
      tests_run++;
      if (ID_rs1_data !== 32'h33 || instret !== 64'd1) begin
         tests_failed++;
         $display("FAIL post_release_edge: got x3=%h instret=%0d expected 00000033 1", ID_rs1_data, instret);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_bubble();
      test_write_read();
      test_jal();
      test_x0();
      test_same_cycle();
      test_instret_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
